wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
// - Writeback arbiter that drives the GPR register file write port (wen/wreg/wdata).
// - Merges two result sources:
//   - primary: the in-order pipeline result, no backpressure;
//   - secondary: long-latency unit results (mul/div, uncached load), valid/ready handshake.
// - Secondary results are buffered in a small FIFO.
// - Exports a pending-register mask so decode can stall on queued results.
// - A starvation guard ensures the FIFO always drains.
// PARAMETERS
// - DEPTH      2   secondary FIFO entries (power of 2, >=2)
// - STARVE_MAX 4   max consecutive primary wins while FIFO non-empty before a forced pop
// PORTS
// - clk        in   1   clock; all state updates on posedge
// - resetn     in   1   synchronous active-low reset
// - p_valid    in   1   primary result valid this cycle
// - p_wreg     in   5   primary destination register
// - p_wdata    in   32  primary write data
// - p_pc       in   32  primary instruction PC (used only with WB_TRACE_EN)
// - p_stall    out  1   primary not accepted this cycle; upstream holds p_* unchanged
// - s_valid    in   1   secondary result valid
// - s_ready    out  1   secondary FIFO can accept
// - s_wreg     in   5   secondary destination register
// - s_wdata    in   32  secondary write data
// - s_pc       in   32  secondary instruction PC (used only with WB_TRACE_EN)
// - pend_mask  out  32  bit r = 1 while any FIFO entry targets GPR r
// - rf_wen     out  1   regfile write enable (registered)
// - rf_wreg    out  5   regfile write register (registered)
// - rf_wdata   out  32  regfile write data (registered)
// BEHAVIOUR
// - Reset (resetn=0 at posedge):
//   - FIFO empty, starve counter 0.
//   - rf_wen/rf_wreg/rf_wdata = 0, pend_mask = 0.
//   - s_ready and p_stall forced 0 while resetn=0.
// - Secondary accept: s_valid && s_ready at posedge.
//   - s_ready = !full, taken from the registered count only.
//   - A full FIFO never accepts, even in a cycle when it pops.
//   - An accepted entry with s_wreg==0 completes the handshake but is discarded (not enqueued).
// - Selection, evaluated each cycle from registered state:
//   - force = (starve_cnt==STARVE_MAX) && !empty.
//   - p_stall = p_valid && force.
//   - If p_valid && !force: output stage <= primary.
//     - If p_wreg==0, rf_wen <= 0 (write dropped).
//   - Else if !empty: pop FIFO head into output stage; rf_wen <= 1.
//   - Else: rf_wen <= 0. rf_wreg/rf_wdata hold their previous values.
// - Starve counter:
//   - Increments when the primary wins while the FIFO is non-empty.
//   - Clears on any pop or when the FIFO is empty.
//   - Saturates at STARVE_MAX.
// - Latency:
//   - Primary: rf_* valid 1 cycle after the accepting edge.
//   - Secondary: at least 2 cycles (push edge, then pop edge). No empty-FIFO bypass.
// - Simultaneous push+pop on a non-full FIFO: both occur; count unchanged.
// - Pointers are log2(DEPTH) bits and wrap naturally.
// - pend_mask:
//   - Combinational OR of one-hot(wreg) over valid FIFO entries.
//   - The output stage is excluded; the regfile's write bypass covers it.
// - Ordering:
//   - No WAW check between the primary and the FIFO.
//   - Issue logic must use pend_mask so no younger write targets a pending register.
// - Reset mid-operation: queued entries are lost; rf_wen=0 on the next cycle.
// CONFIGURATION
// - Macro WB_TRACE_EN defined:
//   - FIFO also stores pc.
//   - Extra outputs, registered alongside rf_*:
//     - debug_wb_pc[31:0]
//     - debug_wb_rf_wen[3:0] = {4{rf_wen}}
//     - debug_wb_rf_wnum[4:0] = rf_wreg
//     - debug_wb_rf_wdata[31:0] = rf_wdata
// - Macro WB_TRACE_EN undefined:
//   - No debug ports and no pc storage.
//   - p_pc/s_pc are ignored.
//   - rf_* behaviour is identical.
// TESTING
// - Reset: hold resetn=0 with p_valid=1, s_valid=1
//   -> rf_wen=0, s_ready=0, pend_mask=0; no write after release until a new valid.
// - Primary only: p_valid, wreg=5, wdata=0xDEADBEEF
//   -> next cycle rf_wen=1, rf_wreg=5, rf_wdata=0xDEADBEEF.
//   - Same with wreg=0 -> rf_wen=0.
// - Secondary, idle primary: s_valid, wreg=3, data=0x12
//   -> pend_mask=0x8 one cycle after the push edge; rf_wen=1, rf_wreg=3 the cycle after; then pend_mask=0.
// - Full FIFO: push 2 entries while p_valid=1 continuously
//   -> s_ready=0; a third s_valid is held, not lost.
// - Starvation: FIFO non-empty, p_valid=1 continuously
//   -> exactly 4 primary writes, then p_stall=1 for one cycle with a FIFO pop;
//   -> the held primary is written the next cycle with unchanged data.
// - Trace (WB_TRACE_EN): secondary pc=0xBFC00100
//   -> debug_wb_pc=0xBFC00100 and debug_wb_rf_wen=4'hF in the same cycle as rf_wen.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: primary/secondary result sources, pending mask and regfile write port.
// Trace outputs exist only when WB_TRACE_EN is defined.
interface wb_arbiter_if;
  logic        p_valid;
  logic [4:0]  p_wreg;
  logic [31:0] p_wdata;
  logic [31:0] p_pc;
  logic        p_stall;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_wreg;
  logic [31:0] s_wdata;
  logic [31:0] s_pc;
  logic [31:0] pend_mask;
  logic        rf_wen;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  modport slave (
    input  p_valid, p_wreg, p_wdata, p_pc,
    input  s_valid, s_wreg, s_wdata, s_pc,
    output p_stall, s_ready, pend_mask,
    output rf_wen, rf_wreg, rf_wdata
`ifdef WB_TRACE_EN
    , output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
  );

  modport master (
    output p_valid, p_wreg, p_wdata, p_pc,
    output s_valid, s_wreg, s_wdata, s_pc,
    input  p_stall, s_ready, pend_mask,
    input  rf_wen, rf_wreg, rf_wdata
`ifdef WB_TRACE_EN
    , input debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
`endif
  );
endinterface

// File: rtl/wb_arbiter.sv
// GPR writeback arbiter: primary pipeline result vs. FIFO-buffered long-latency results,
// with starvation guard and pending-register mask. WB_TRACE_EN adds pc tracing outputs.
module wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
`ifdef WB_TRACE_EN
    logic [31:0] pc;
`endif
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic [SW-1:0]    starve;
  logic             empty, full, frc, p_win, pop, push;
  logic [31:0]      pend;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign frc   = (starve == SW'(STARVE_MAX)) && !empty;
  assign p_win = bus.p_valid && !frc;
  assign pop   = !p_win && !empty;
  // wreg 0 completes the handshake but never occupies a slot
  assign push  = bus.s_valid && bus.s_ready && (bus.s_wreg != 5'd0);

  assign bus.s_ready   = resetn && !full;
  assign bus.p_stall   = resetn && bus.p_valid && frc;
  assign bus.pend_mask = pend;

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_vld[i]) pend[mem[i].wreg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr].wreg  <= bus.s_wreg;
      mem[wptr].wdata <= bus.s_wdata;
`ifdef WB_TRACE_EN
      mem[wptr].pc    <= bus.s_pc;
`endif
    end
  end

  // push and pop never hit the same slot: pop needs non-empty, push needs non-full
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      slot_vld <= '0;
    end else begin
      if (push) begin
        wptr           <= wptr + 1'b1;
        slot_vld[wptr] <= 1'b1;
      end
      if (pop) begin
        rptr           <= rptr + 1'b1;
        slot_vld[rptr] <= 1'b0;
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                                  starve <= '0;
    else if (pop || empty)                        starve <= '0;
    else if (p_win && starve != SW'(STARVE_MAX))  starve <= starve + 1'b1;
  end

  logic [4:0]  rf_wreg_q;
  logic [31:0] rf_wdata_q;
  logic        rf_wen_q;
`ifdef WB_TRACE_EN
  logic [31:0] pc_q;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_wen_q   <= 1'b0;
      rf_wreg_q  <= '0;
      rf_wdata_q <= '0;
`ifdef WB_TRACE_EN
      pc_q       <= '0;
`endif
    end else if (p_win) begin
      rf_wen_q   <= (bus.p_wreg != 5'd0);
      rf_wreg_q  <= bus.p_wreg;
      rf_wdata_q <= bus.p_wdata;
`ifdef WB_TRACE_EN
      pc_q       <= bus.p_pc;
`endif
    end else if (pop) begin
      rf_wen_q   <= 1'b1;
      rf_wreg_q  <= mem[rptr].wreg;
      rf_wdata_q <= mem[rptr].wdata;
`ifdef WB_TRACE_EN
      pc_q       <= mem[rptr].pc;
`endif
    end else begin
      rf_wen_q   <= 1'b0;
    end
  end

  assign bus.rf_wen   = rf_wen_q;
  assign bus.rf_wreg  = rf_wreg_q;
  assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_TRACE_EN
  assign bus.debug_wb_pc       = pc_q;
  assign bus.debug_wb_rf_wen   = {4{rf_wen_q}};
  assign bus.debug_wb_rf_wnum  = rf_wreg_q;
  assign bus.debug_wb_rf_wdata = rf_wdata_q;
`else
  logic unused_pc;
  assign unused_pc = ^{bus.p_pc, bus.s_pc};
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2, STARVE_MAX=4); trace checks under WB_TRACE_EN.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset with both sources asserting
    resetn = 1'b0;
    bus.p_valid = 1'b1; bus.p_wreg = 5'd7; bus.p_wdata = 32'h1; bus.p_pc = 32'h0;
    bus.s_valid = 1'b1; bus.s_wreg = 5'd9; bus.s_wdata = 32'h2; bus.s_pc = 32'h0;
    tick(); tick();
    chk("rst_rf_wen", bus.rf_wen, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_p_stall", bus.p_stall, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_rf_wreg", bus.rf_wreg, 0);
    bus.p_valid = 1'b0; bus.s_valid = 1'b0; resetn = 1'b1;
    tick();
    chk("rel_rf_wen", bus.rf_wen, 0);
    chk("rel_s_ready", bus.s_ready, 1);
    tick();
    chk("rel_rf_wen2", bus.rf_wen, 0);

    // primary only
    bus.p_valid = 1'b1; bus.p_wreg = 5'd5; bus.p_wdata = 32'hDEADBEEF;
    tick();
    chk("p_rf_wen", bus.rf_wen, 1);
    chk("p_rf_wreg", bus.rf_wreg, 5);
    chk("p_rf_wdata", bus.rf_wdata, 32'hDEADBEEF);
    bus.p_valid = 1'b0;
    tick();
    chk("idle_rf_wen", bus.rf_wen, 0);
    chk("idle_hold_wdata", bus.rf_wdata, 32'hDEADBEEF);
    chk("idle_hold_wreg", bus.rf_wreg, 5);
    bus.p_valid = 1'b1; bus.p_wreg = 5'd0; bus.p_wdata = 32'h55;
    tick();
    chk("p_r0_rf_wen", bus.rf_wen, 0);
    bus.p_valid = 1'b0;

    // secondary with idle primary: 2-cycle latency, no bypass
    bus.s_valid = 1'b1; bus.s_wreg = 5'd3; bus.s_wdata = 32'h12; bus.s_pc = 32'hBFC00100;
    #1;
    chk("s_ready_empty", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    chk("s_pend_after_push", bus.pend_mask, 32'h8);
    chk("s_no_bypass", bus.rf_wen, 0);
    tick();
    chk("s_rf_wen", bus.rf_wen, 1);
    chk("s_rf_wreg", bus.rf_wreg, 3);
    chk("s_rf_wdata", bus.rf_wdata, 32'h12);
    chk("s_pend_cleared", bus.pend_mask, 0);
`ifdef WB_TRACE_EN
    chk("trace_pc", bus.debug_wb_pc, 32'hBFC00100);
    chk("trace_wen", bus.debug_wb_rf_wen, 4'hF);
    chk("trace_wnum", bus.debug_wb_rf_wnum, 3);
`endif

    // secondary to r0 is accepted and dropped
    bus.s_valid = 1'b1; bus.s_wreg = 5'd0; bus.s_wdata = 32'h99;
    tick();
    bus.s_valid = 1'b0;
    chk("s_r0_pend", bus.pend_mask, 0);
    tick();
    chk("s_r0_rf_wen", bus.rf_wen, 0);

    // fill FIFO under continuous primary, then starvation guard
    bus.p_valid = 1'b1; bus.p_wreg = 5'd10; bus.p_wdata = 32'hA0000001;
    bus.s_valid = 1'b1; bus.s_wreg = 5'd4; bus.s_wdata = 32'h40;
    tick();
    chk("f1_rf_wdata", bus.rf_wdata, 32'hA0000001);
    chk("f1_pend", bus.pend_mask, 32'h10);
    bus.p_wdata = 32'hA0000002;
    bus.s_wreg = 5'd6; bus.s_wdata = 32'h60;
    tick();
    chk("f2_rf_wdata", bus.rf_wdata, 32'hA0000002);
    chk("f2_pend", bus.pend_mask, 32'h50);
    bus.s_wreg = 5'd8; bus.s_wdata = 32'h80;
    #1;
    chk("full_s_ready", bus.s_ready, 0);
    for (int k = 3; k <= 5; k++) begin
      chk("starve_no_stall", bus.p_stall, 0);
      bus.p_wdata = 32'hA0000000 + 32'(k);
      tick();
      chk("starve_p_write", bus.rf_wdata, 32'hA0000000 + 32'(k));
      chk("starve_p_wen", bus.rf_wen, 1);
    end
    bus.p_wdata = 32'hA0000006;
    #1;
    chk("force_p_stall", bus.p_stall, 1);
    chk("force_s_ready", bus.s_ready, 0);
    tick();
    chk("force_pop_wen", bus.rf_wen, 1);
    chk("force_pop_wreg", bus.rf_wreg, 4);
    chk("force_pop_wdata", bus.rf_wdata, 32'h40);
    chk("force_p_stall_off", bus.p_stall, 0);
    chk("held_s_ready", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    chk("held_p_wreg", bus.rf_wreg, 10);
    chk("held_p_wdata", bus.rf_wdata, 32'hA0000006);
    chk("held_s_pend", bus.pend_mask, 32'h140);
    bus.p_valid = 1'b0;
    tick();
    chk("drain1_wreg", bus.rf_wreg, 6);
    chk("drain1_wdata", bus.rf_wdata, 32'h60);
    tick();
    chk("drain2_wreg", bus.rf_wreg, 8);
    chk("drain2_wdata", bus.rf_wdata, 32'h80);
    chk("drain2_pend", bus.pend_mask, 0);
    tick();
    chk("drain_done_wen", bus.rf_wen, 0);

    // reset mid-operation drops queued entry
    bus.p_valid = 1'b1; bus.p_wreg = 5'd11; bus.p_wdata = 32'hB;
    bus.s_valid = 1'b1; bus.s_wreg = 5'd12; bus.s_wdata = 32'hC;
    tick();
    bus.s_valid = 1'b0;
    chk("mid_pend", bus.pend_mask, 32'h1000);
    resetn = 1'b0;
    tick();
    chk("mid_rst_wen", bus.rf_wen, 0);
    chk("mid_rst_pend", bus.pend_mask, 0);
    bus.p_valid = 1'b0; resetn = 1'b1;
    tick();
    chk("mid_lost_wen", bus.rf_wen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
